hyperram_rd_capture: RTL and testbench

//  Consumes per-cycle IDDR outputs for HyperRAM DQ[7:0] and RWDS, one IDDRX1F per pin.

---
 rtl/hyperram_rd_capture_if.sv | 48 ++++
 rtl/hyperram_rd_capture.sv | 231 +++++++++++++++++++++++
 tb/tb_hyperram_rd_capture.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hyperram_rd_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : hyperram_rd_capture_if
// Description : Bundle of the burst-control, IDDR capture and word-stream
//               signals of the HyperRAM read-capture block.
//               master : controller / IDDR / consumer side (drives start, len,
//                        DQ/RWDS samples and m_ready)
//               slave  : the capture block itself
// Signals     : start, len        burst request and length in words
//               dq_ris, dq_fal    DQ bytes from IDDR Q0 / Q1
//               rwds_ris/_fal     RWDS samples from IDDR Q0 / Q1
//               busy, done,       burst status toward the controller FSM
//               timeout_err, ovf
//               m_data, m_valid,  16-bit word stream out of the FIFO
//               m_ready
//               level             FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
interface hyperram_rd_capture_if #(
    parameter int LEN_W = 8,
    parameter int DEPTH = 4
);
    logic                     start;
    logic [LEN_W-1:0]         len;
    logic [7:0]               dq_ris;
    logic [7:0]               dq_fal;
    logic                     rwds_ris;
    logic                     rwds_fal;
    logic                     busy;
    logic                     done;
    logic                     timeout_err;
    logic                     ovf;
    logic [15:0]              m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output start, len, dq_ris, dq_fal, rwds_ris, rwds_fal, m_ready,
        input  busy, done, timeout_err, ovf, m_data, m_valid, level
    );

    modport slave (
        input  start, len, dq_ris, dq_fal, rwds_ris, rwds_fal, m_ready,
        output busy, done, timeout_err, ovf, m_data, m_valid, level
    );
endinterface
`default_nettype wire

// File: rtl/hyperram_rd_capture.sv
`default_nettype none
// ============================================================================
// Module      : hyperram_rd_capture
// Description : HyperRAM read-data capture. Takes the per-cycle IDDR outputs
//               of DQ[7:0] and RWDS, qualifies each cycle on the RWDS phase,
//               assembles 16-bit words (rising byte = MSB), counts a commanded
//               burst length and buffers the words in a small FIFO with a
//               valid/ready output. Initial-latency and inter-word gap
//               timeouts abort the burst; words arriving on a full FIFO are
//               dropped and flagged through a sticky overflow bit.
// Parameters  : DEPTH   FIFO depth in words (power of 2, >= 2)
//               LEN_W   width of the burst length
//               LAT_MAX max silent cycles before the first word
//               GAP_MAX max silent cycles between consecutive words
// Ports       : clk     system clock (IDDR SCLK domain)
//               rst_n   asynchronous active-low reset
//               bus     hyperram_rd_capture_if.slave
//                         in : start, len, dq_ris, dq_fal, rwds_ris,
//                              rwds_fal, m_ready
//                         out: busy, done, timeout_err, ovf, m_data,
//                              m_valid, level
// Revision    : 1.0 - initial release
// ============================================================================
module hyperram_rd_capture #(
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 8,
    parameter int LAT_MAX = 64,
    parameter int GAP_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hyperram_rd_capture_if.slave  bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_LVL_W   = c_PTR_W + 1;
    localparam int c_TMR_MAX = (LAT_MAX > GAP_MAX) ? LAT_MAX : GAP_MAX;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_TMR_W-1:0] c_LAT_LAST = c_TMR_W'(LAT_MAX - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_LAST = c_TMR_W'(GAP_MAX - 1);
    localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);

    // ------------------------------------------------------------------
    // Burst sequencer state
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,   // waiting for the first word (initial latency)
        S_BURST = 2'd2,   // at least one word seen, gap limit applies
        S_DONE  = 2'd3    // one-cycle completion pulse
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LEN_W-1:0]    r_remaining;
    logic [LEN_W-1:0]    w_remaining_nxt;
    logic [c_TMR_W-1:0]  r_tmr;
    logic [c_TMR_W-1:0]  w_tmr_nxt;
    logic                r_abort;       // DONE was reached through a timeout
    logic                w_abort_nxt;

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    logic [15:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic                r_ovf;

    // ------------------------------------------------------------------
    // Capture qualification
    // ------------------------------------------------------------------
    logic        w_word_vld;
    logic [15:0] w_word;
    logic        w_capture;     // a data word arrives while a burst is open
    logic        w_tmr_last;    // silent-cycle limit reached this cycle
    logic        w_start_acc;

    // Data is only present when RWDS toggles high-then-low within the
    // cycle; every other RWDS pattern is a bubble.
    assign w_word_vld  = bus.rwds_ris & ~bus.rwds_fal;
    assign w_word      = {bus.dq_ris, bus.dq_fal};
    assign w_start_acc = (r_state == S_IDLE) & bus.start;
    assign w_tmr_last  = (r_state == S_WAIT) ? (r_tmr == c_LAT_LAST)
                                             : (r_tmr == c_GAP_LAST);

    // ------------------------------------------------------------------
    // Sequencer: next state and next datapath values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_tmr_nxt       = r_tmr;
        w_abort_nxt     = r_abort;
        w_capture       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_abort_nxt = 1'b0;
                    w_tmr_nxt   = '0;
                    if (bus.len != '0) begin
                        w_state_nxt     = S_WAIT;
                        w_remaining_nxt = bus.len;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end

            S_WAIT, S_BURST: begin
                if (w_word_vld) begin
                    // Dropped words still count toward the burst length,
                    // so the capture request is independent of FIFO space.
                    w_capture       = 1'b1;
                    w_tmr_nxt       = '0;
                    w_remaining_nxt = r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_nxt = S_DONE;
                        w_abort_nxt = 1'b0;
                    end else begin
                        w_state_nxt = S_BURST;
                    end
                end else if (w_tmr_last) begin
                    w_state_nxt = S_DONE;
                    w_abort_nxt = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr + c_TMR_W'(1);
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_tmr       <= '0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_tmr       <= w_tmr_nxt;
            r_abort     <= w_abort_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_drop;

    assign w_pop  = (r_level != '0) & bus.m_ready;
    assign w_full = (r_level == c_FULL_LVL);
    // A simultaneous pop frees the slot the new word lands in; when full,
    // wr_ptr equals rd_ptr so the write overwrites the entry being popped.
    assign w_push = w_capture & (~w_full | w_pop);
    assign w_drop = w_capture & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_LVL_W'(1);
            end
        end
    end

    // Sticky overflow, cleared only by an accepted start. A start and a
    // drop can never coincide since drops only happen inside a burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_start_acc) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.timeout_err = (r_state == S_DONE) & r_abort;
    assign bus.ovf         = r_ovf;
    assign bus.m_data      = r_mem[r_rd_ptr];
    assign bus.m_valid     = (r_level != '0);
    assign bus.level       = r_level;

endmodule
`default_nettype wire

// File: tb/tb_hyperram_rd_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_hyperram_rd_capture
// Description : Self-checking bench for hyperram_rd_capture. A behavioural
//               model predicts the status outputs each cycle and pushes every
//               word it expects the FIFO to accept onto a scoreboard queue;
//               an independent monitor pops and compares whenever the DUT
//               hands a word out (m_valid & m_ready).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hyperram_rd_capture;

    localparam int DEPTH   = 4;
    localparam int LEN_W   = 8;
    localparam int LAT_MAX = 64;
    localparam int GAP_MAX = 4;

    logic clk;
    logic rst_n;

    hyperram_rd_capture_if #(.LEN_W(LEN_W), .DEPTH(DEPTH)) bus ();

    hyperram_rd_capture #(
        .DEPTH   (DEPTH),
        .LEN_W   (LEN_W),
        .LAT_MAX (LAT_MAX),
        .GAP_MAX (GAP_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] exp_q    [$];   // scoreboard: words the consumer must see
    logic [15:0] mdl_fifo [$];   // model FIFO contents

    // Burst model in terms of words left and consecutive silent cycles.
    bit mdl_active;
    bit mdl_done_now;
    bit mdl_err;
    bit mdl_got_any;
    bit mdl_ovf;
    int mdl_left;
    int mdl_silence;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_active   = 0;
        mdl_done_now = 0;
        mdl_err      = 0;
        mdl_got_any  = 0;
        mdl_ovf      = 0;
        mdl_left     = 0;
        mdl_silence  = 0;
        mdl_fifo.delete();
        exp_q.delete();
    endtask

    task automatic check_outputs();
        check("busy",        bus.busy,        32'(mdl_active || mdl_done_now));
        check("done",        bus.done,        32'(mdl_done_now));
        check("timeout_err", bus.timeout_err, 32'(mdl_done_now && mdl_err));
        check("ovf",         bus.ovf,         32'(mdl_ovf));
        check("level",       bus.level,       32'(mdl_fifo.size()));
        check("m_valid",     bus.m_valid,     32'(mdl_fifo.size() != 0));
    endtask

    // Advances the model across one clock edge using the inputs now applied.
    task automatic model_step();
        bit          word;
        bit          pop;
        bit          capture;
        logic [15:0] w;
        word    = bus.rwds_ris && !bus.rwds_fal;
        w       = {bus.dq_ris, bus.dq_fal};
        pop     = (mdl_fifo.size() > 0) && bus.m_ready;
        capture = 0;
        if (mdl_done_now) begin
            mdl_done_now = 0;
            mdl_err      = 0;
        end else if (!mdl_active) begin
            if (bus.start) begin
                mdl_ovf = 0;
                if (bus.len == 0) begin
                    mdl_done_now = 1;
                    mdl_err      = 0;
                end else begin
                    mdl_active  = 1;
                    mdl_left    = int'(bus.len);
                    mdl_silence = 0;
                    mdl_got_any = 0;
                end
            end
        end else if (word) begin
            capture     = 1;
            mdl_left    = mdl_left - 1;
            mdl_silence = 0;
            mdl_got_any = 1;
            if (mdl_left == 0) begin
                mdl_active   = 0;
                mdl_done_now = 1;
                mdl_err      = 0;
            end
        end else begin
            mdl_silence = mdl_silence + 1;
            if (mdl_silence == (mdl_got_any ? GAP_MAX : LAT_MAX)) begin
                mdl_active   = 0;
                mdl_done_now = 1;
                mdl_err      = 1;
            end
        end
        if (pop) begin
            void'(mdl_fifo.pop_front());
        end
        if (capture) begin
            if (mdl_fifo.size() < DEPTH) begin
                mdl_fifo.push_back(w);
                exp_q.push_back(w);
            end else begin
                mdl_ovf = 1;
            end
        end
    endtask

    // One clock cycle: check mid-cycle, step the model, return just after
    // the next rising edge so the caller can apply the next inputs.
    task automatic tick();
        @(negedge clk);
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [15:0] w);
        bus.rwds_ris = 1'b1;
        bus.rwds_fal = 1'b0;
        bus.dq_ris   = w[15:8];
        bus.dq_fal   = w[7:0];
    endtask

    task automatic drive_noword();
        int p;
        p = int'($urandom_range(0, 2));
        bus.rwds_ris = (p == 1);
        bus.rwds_fal = (p != 0);
        bus.dq_ris   = 8'($urandom);
        bus.dq_fal   = 8'($urandom);
    endtask

    task automatic drive_start(input int n);
        bus.start = 1'b1;
        bus.len   = LEN_W'(n);
        drive_noword();
        tick();
        bus.start = 1'b0;
    endtask

    // Scoreboard monitor: compares every word handed to the consumer.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL m_data: got %h, expected no word at %0t", bus.m_data, $time);
            end else begin
                check("m_data", bus.m_data, 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before %0t", $time);
        $fatal(1);
    end

    logic [15:0] dir_words [4];

    initial begin
        dir_words[0] = 16'hA1B2;
        dir_words[1] = 16'hC3D4;
        dir_words[2] = 16'hE5F6;
        dir_words[3] = 16'h0718;

        bus.start    = 1'b0;
        bus.len      = '0;
        bus.dq_ris   = '0;
        bus.dq_fal   = '0;
        bus.rwds_ris = 1'b0;
        bus.rwds_fal = 1'b0;
        bus.m_ready  = 1'b0;
        rst_n        = 1'b1;
        model_reset();

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy",    bus.busy,        0);
        check("rst_done",    bus.done,        0);
        check("rst_err",     bus.timeout_err, 0);
        check("rst_ovf",     bus.ovf,         0);
        check("rst_m_valid", bus.m_valid,     0);
        check("rst_m_data",  bus.m_data,      0);
        check("rst_level",   bus.level,       0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back burst of four words
        bus.m_ready = 1'b1;
        drive_start(4);
        for (int i = 0; i < 4; i++) begin
            drive_word(dir_words[i]);
            tick();
        end
        check("b2b_done", bus.done,        1);
        check("b2b_err",  bus.timeout_err, 0);
        drive_noword();
        tick();
        tick();

        // Initial-latency timeout
        drive_start(2);
        repeat (LAT_MAX) begin
            drive_noword();
            tick();
        end
        check("lat_done",    bus.done,        1);
        check("lat_err",     bus.timeout_err, 1);
        check("lat_m_valid", bus.m_valid,     0);
        tick();

        // One word, then an inter-word gap timeout
        bus.m_ready = 1'b0;
        drive_start(3);
        drive_word(16'($urandom));
        tick();
        repeat (GAP_MAX) begin
            drive_noword();
            tick();
        end
        check("gap_done",  bus.done,        1);
        check("gap_err",   bus.timeout_err, 1);
        check("gap_level", bus.level,       1);
        tick();

        // Drain, then overflow with a stalled consumer
        bus.m_ready = 1'b1;
        repeat (2) tick();
        bus.m_ready = 1'b0;
        drive_start(6);
        for (int i = 0; i < 6; i++) begin
            drive_word(16'($urandom));
            tick();
        end
        check("ovf_done",  bus.done,        1);
        check("ovf_err",   bus.timeout_err, 0);
        check("ovf_flag",  bus.ovf,         1);
        check("ovf_level", bus.level,       DEPTH);
        drive_noword();
        tick();

        // New start clears ovf; push onto a full FIFO with a simultaneous pop
        drive_start(1);
        check("ovf_clear", bus.ovf,   0);
        check("full_lvl0", bus.level, DEPTH);
        bus.m_ready = 1'b1;
        drive_word(16'h5AA5);
        tick();
        check("pp_level", bus.level, DEPTH);
        check("pp_ovf",   bus.ovf,   0);
        check("pp_done",  bus.done,  1);
        drive_noword();
        repeat (DEPTH + 2) tick();

        // Zero-length burst
        drive_start(0);
        check("len0_busy", bus.busy,        1);
        check("len0_done", bus.done,        1);
        check("len0_err",  bus.timeout_err, 0);
        tick();
        check("len0_idle", bus.busy,        0);

        // Start while busy is ignored
        drive_start(3);
        bus.start = 1'b1;
        bus.len   = LEN_W'(7);
        drive_word(16'h1111);
        tick();
        bus.start = 1'b0;
        drive_word(16'h2222);
        tick();
        drive_word(16'h3333);
        tick();
        check("busy_start_done", bus.done, 1);
        drive_noword();
        tick();

        // Randomized traffic
        begin
            int pct;
            pct = 90;
            for (int c = 0; c < 3000; c++) begin
                if (c % 80 == 0) begin
                    case ($urandom_range(0, 3))
                        0: pct = 90;
                        1: pct = 50;
                        2: pct = 10;
                        default: pct = 0;
                    endcase
                end
                bus.start   = ($urandom_range(0, 3) == 0);
                bus.len     = LEN_W'($urandom_range(0, 7));
                bus.m_ready = ($urandom_range(0, 9) < 7);
                if (int'($urandom_range(0, 99)) < pct) begin
                    drive_word(16'($urandom));
                end else begin
                    drive_noword();
                end
                tick();
            end
            bus.start = 1'b0;
        end

        // Let any burst left open by the random phase finish
        bus.m_ready = 1'b1;
        drive_noword();
        repeat (LAT_MAX + 4) tick();

        // Asynchronous reset in the middle of a burst
        bus.m_ready = 1'b0;
        drive_start(5);
        drive_word(16'hBEEF);
        tick();
        drive_word(16'hCAFE);
        tick();
        drive_noword();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",    bus.busy,        0);
        check("arst_done",    bus.done,        0);
        check("arst_err",     bus.timeout_err, 0);
        check("arst_ovf",     bus.ovf,         0);
        check("arst_m_valid", bus.m_valid,     0);
        check("arst_m_data",  bus.m_data,      0);
        check("arst_level",   bus.level,       0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) tick();

        // Final drain
        bus.m_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
